// File: rtl/riscvio2i_rob_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscvio2i_rob_ctrl_pkg
//   Shared definitions for the IO2I reorder-buffer control slice.
//   - Default ROB geometry: entry count, slot index width, RF address width.
//   - Bit layout of one ROB entry when it is held as a packed word.
//     The waddr field sits at the top of the word, so the layout stays valid
//     for any register width.
// -----------------------------------------------------------------------------
package riscvio2i_rob_ctrl_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int ROB_SLOT_W  = 4;
    localparam int ROB_REG_W   = 5;

    // Entry field bit positions (waddr occupies [ENT_WADDR +: REG_W]).
    localparam int ENT_VALID  = 0;
    localparam int ENT_FILLED = 1;
    localparam int ENT_WEN    = 2;
    localparam int ENT_WADDR  = 3;

endpackage

// File: rtl/riscvio2i_rob_ctrl_lookup.sv
// -----------------------------------------------------------------------------
// riscvio2i_rob_lookup
//   Combinational scoreboard lookup for one source operand. Finds the youngest
//   ROB entry (relative to head) that is valid, writes the RF, and targets
//   raddr_i. Register x0 never hits.
//
// Ports
//   valid_i, wen_i, filled_i  per-entry state bits
//   waddr_i                   per-entry destination register
//   head_i                    oldest slot; ages are measured from here
//   raddr_i                   source register being looked up
//   hit_o                     a matching entry is in flight
//   slot_o                    youngest matching slot (0 when no hit)
//   ready_o                   that entry is filled (0 when no hit)
// -----------------------------------------------------------------------------
module riscvio2i_rob_lookup
    import riscvio2i_rob_ctrl_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int SLOT_W  = ROB_SLOT_W,
    parameter int REG_W   = ROB_REG_W
) (
    input  logic [ENTRIES-1:0]            valid_i,
    input  logic [ENTRIES-1:0]            wen_i,
    input  logic [ENTRIES-1:0]            filled_i,
    input  logic [ENTRIES-1:0][REG_W-1:0] waddr_i,
    input  logic [SLOT_W-1:0]             head_i,
    input  logic [REG_W-1:0]              raddr_i,
    output logic                          hit_o,
    output logic [SLOT_W-1:0]             slot_o,
    output logic                          ready_o
);

    logic [ENTRIES-1:0] match;
    logic [SLOT_W-1:0]  idx;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
        assign match[i] = valid_i[i] & wen_i[i] & (waddr_i[i] == raddr_i)
                        & (raddr_i != '0);
    end

    // Walk slots oldest to youngest; the last match seen is the youngest,
    // which is the producer a newly issued reader must depend on.
    always_comb begin
        hit_o   = 1'b0;
        slot_o  = '0;
        ready_o = 1'b0;
        idx     = '0;
        for (int a = 0; a < ENTRIES; a++) begin
            idx = head_i + SLOT_W'(a);
            if (match[idx]) begin
                hit_o   = 1'b1;
                slot_o  = idx;
                ready_o = filled_i[idx];
            end
        end
    end

endmodule

// File: rtl/riscvio2i_rob_ctrl.sv
// -----------------------------------------------------------------------------
// riscvio2i_rob_ctrl
//   Reorder-buffer control for the in-order-issue, out-of-order-completion
//   core. Allocates slots in program order at issue, marks them filled at
//   writeback, retires the oldest filled entry (driving the RF commit write)
//   and answers per-operand scoreboard lookups.
//
// Configuration macro
//   RISCVIO2I_ROB_FLUSH_EN  adds the `flush` input: discards every in-flight
//                           entry (tail snaps to head) and suppresses retire,
//                           alloc and fill for that cycle.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   flush                       (RISCVIO2I_ROB_FLUSH_EN only) pipeline flush
//   alloc_val/alloc_rdy         issue request / slot available (not full)
//   alloc_wen, alloc_waddr      destination info of the allocated instruction
//   alloc_slot                  slot granted (tail pointer)
//   fill_val, fill_slot         writeback result deposited into slot
//   srcN_raddr                  source register lookups (N = 0, 1)
//   srcN_hit/_slot/_ready       in flight / youngest producer slot / bypassable
//   commit_wen/_slot/_waddr     RF write from the ROB head
//   retire                      head entry leaves at this edge
//   empty, count                occupancy
//
// All outputs are combinational from registered state (lookups also depend on
// the raddr inputs); same-cycle alloc/fill are not visible until the next cycle.
// -----------------------------------------------------------------------------
module riscvio2i_rob_ctrl
    import riscvio2i_rob_ctrl_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int SLOT_W  = ROB_SLOT_W,
    parameter int REG_W   = ROB_REG_W
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RISCVIO2I_ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_val,
    output logic              alloc_rdy,
    input  logic              alloc_wen,
    input  logic [REG_W-1:0]  alloc_waddr,
    output logic [SLOT_W-1:0] alloc_slot,
    input  logic              fill_val,
    input  logic [SLOT_W-1:0] fill_slot,
    input  logic [REG_W-1:0]  src0_raddr,
    input  logic [REG_W-1:0]  src1_raddr,
    output logic              src0_hit,
    output logic              src1_hit,
    output logic [SLOT_W-1:0] src0_slot,
    output logic [SLOT_W-1:0] src1_slot,
    output logic              src0_ready,
    output logic              src1_ready,
    output logic              commit_wen,
    output logic [SLOT_W-1:0] commit_slot,
    output logic [REG_W-1:0]  commit_waddr,
    output logic              retire,
    output logic              empty,
    output logic [SLOT_W:0]   count
);

    localparam int EW = ENT_WADDR + REG_W;

    if (ENTRIES != (1 << SLOT_W)) begin : g_bad_geometry
        $error("riscvio2i_rob_ctrl: ENTRIES must equal 2**SLOT_W");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0][EW-1:0] ent_q, ent_d;
    logic [SLOT_W-1:0]          head_q, head_d;
    logic [SLOT_W-1:0]          tail_q, tail_d;
    logic [SLOT_W:0]            count_q, count_d;

    // Field views of the entry words.
    logic [ENTRIES-1:0]            ent_valid, ent_filled, ent_wen;
    logic [ENTRIES-1:0][REG_W-1:0] ent_waddr;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_fields
        assign ent_valid[i]  = ent_q[i][ENT_VALID];
        assign ent_filled[i] = ent_q[i][ENT_FILLED];
        assign ent_wen[i]    = ent_q[i][ENT_WEN];
        assign ent_waddr[i]  = ent_q[i][ENT_WADDR +: REG_W];
    end

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic flush_act;
    logic full;
    logic alloc_ok;
    logic fill_ok;

`ifdef RISCVIO2I_ROB_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Full is judged on registered count only; a same-cycle retire is not
    // credited, so alloc can never land on the slot that is retiring.
    assign full     = (count_q == (SLOT_W+1)'(ENTRIES));
    assign alloc_ok = alloc_val & ~full & ~flush_act;
    assign fill_ok  = fill_val & ent_valid[fill_slot] & ~ent_filled[fill_slot]
                    & ~flush_act;

    assign retire       = ent_valid[head_q] & ent_filled[head_q] & ~flush_act;
    assign commit_wen   = retire & ent_wen[head_q] & (ent_waddr[head_q] != '0);
    assign commit_slot  = head_q;
    assign commit_waddr = ent_waddr[head_q];

    assign alloc_rdy  = ~full;
    assign alloc_slot = tail_q;
    assign empty      = (count_q == '0);
    assign count      = count_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush_act) begin
            // Head stays put: the flush discards everything younger than
            // the last retired instruction, so the next alloc reuses head.
            for (int i = 0; i < ENTRIES; i++) begin
                ent_d[i][ENT_VALID]  = 1'b0;
                ent_d[i][ENT_FILLED] = 1'b0;
            end
            tail_d  = head_q;
            count_d = '0;
        end else begin
            if (retire) begin
                ent_d[head_q][ENT_VALID] = 1'b0;
                head_d = head_q + 1'b1;
            end

            if (fill_ok) begin
                ent_d[fill_slot][ENT_FILLED] = 1'b1;
            end

            if (alloc_ok) begin
                ent_d[tail_q][ENT_VALID]            = 1'b1;
                ent_d[tail_q][ENT_FILLED]           = 1'b0;
                ent_d[tail_q][ENT_WEN]              = alloc_wen;
                ent_d[tail_q][ENT_WADDR +: REG_W]   = alloc_waddr;
                tail_d = tail_q + 1'b1;
            end

            unique case ({alloc_ok, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard lookups, one per source operand
    // ------------------------------------------------------------------
    riscvio2i_rob_lookup #(
        .ENTRIES (ENTRIES),
        .SLOT_W  (SLOT_W),
        .REG_W   (REG_W)
    ) u_lookup_src0 (
        .valid_i  (ent_valid),
        .wen_i    (ent_wen),
        .filled_i (ent_filled),
        .waddr_i  (ent_waddr),
        .head_i   (head_q),
        .raddr_i  (src0_raddr),
        .hit_o    (src0_hit),
        .slot_o   (src0_slot),
        .ready_o  (src0_ready)
    );

    riscvio2i_rob_lookup #(
        .ENTRIES (ENTRIES),
        .SLOT_W  (SLOT_W),
        .REG_W   (REG_W)
    ) u_lookup_src1 (
        .valid_i  (ent_valid),
        .wen_i    (ent_wen),
        .filled_i (ent_filled),
        .waddr_i  (ent_waddr),
        .head_i   (head_q),
        .raddr_i  (src1_raddr),
        .hit_o    (src1_hit),
        .slot_o   (src1_slot),
        .ready_o  (src1_ready)
    );

`ifndef SYNTHESIS
    // Writeback must only target an in-flight, not-yet-filled slot.
    fill_target_legal: assert property (
        @(posedge clk) disable iff (reset)
        fill_val |-> (ent_valid[fill_slot] && !ent_filled[fill_slot])
    );
`endif

endmodule
